toggle_activity_counter: RTL

- Switching-activity monitor for gate-level FSM netlists built from the delayed cell library.
- Samples up to N_SIG netlist nodes on the system clock over a programmable window and counts 0->1 and 1->0 transitions per node.
- Results feed power-estimation comparisons between the behavioural and synthesized versions of a design.
- Synthesizable, so it can run alongside the DUT in the same testbench.

---
 rtl/toggle_activity_counter.sv | 107 ++++++++++
 1 files changed

// File: rtl/toggle_activity_counter.sv
// toggle_activity_counter: counts per-node 0->1/1->0 transitions over a programmable window.
// Per-node and total counters saturate; overflow is sticky until the next start.
module toggle_activity_counter #(
    parameter int N_SIG = 4,
    parameter int CNT_W = 16,
    parameter int WIN_W = 16,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic [N_SIG-1:0] sig_in,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] sel_cnt,
    output logic [CNT_W-1:0] total_cnt,
    output logic             busy,
    output logic             done,
    output logic             overflow
);
    localparam int PC_W = $clog2(N_SIG + 1);
    localparam logic [CNT_W-1:0] MAX = '1;

    typedef enum logic [1:0] {IDLE = 2'b00, COUNT = 2'b01, DONE = 2'b10} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [N_SIG];
    logic [CNT_W-1:0] cnt_d [N_SIG];
    logic [CNT_W-1:0] total_q, total_d;
    logic [WIN_W-1:0] rem_q, rem_d;
    logic [N_SIG-1:0] prev_q, prev_d;
    logic             ovf_q, ovf_d;
    logic [N_SIG-1:0] tog;
    logic [PC_W-1:0]  pc;
    logic [CNT_W:0]   sum;
    logic             clip;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        rem_d   = rem_q;
        prev_d  = prev_q;
        ovf_d   = ovf_q;
        clip    = 1'b0;
        tog     = sig_in ^ prev_q;
        pc      = '0;
        for (int i = 0; i < N_SIG; i++) pc = pc + PC_W'(tog[i]);
        // one extra bit so the saturation check sees the carry
        sum     = {1'b0, total_q} + (CNT_W+1)'(pc);
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    cnt_d   = '{default: '0};
                    total_d = '0;
                    ovf_d   = 1'b0;
                    prev_d  = sig_in;
                    rem_d   = win_len;
                    state_d = (win_len != '0) ? COUNT : DONE;
                end
            end
            COUNT: begin
                prev_d = sig_in;
                rem_d  = rem_q - WIN_W'(1);
                for (int i = 0; i < N_SIG; i++) begin
                    if (tog[i]) begin
                        if (cnt_q[i] == MAX) clip = 1'b1;
                        else cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                if (sum > {1'b0, MAX}) begin
                    total_d = MAX;
                    clip    = 1'b1;
                end else begin
                    total_d = sum[CNT_W-1:0];
                end
                ovf_d   = ovf_q | clip;
                state_d = (rem_q == WIN_W'(1)) ? DONE : COUNT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            cnt_q   <= '{default: '0};
            total_q <= '0;
            rem_q   <= '0;
            prev_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            rem_q   <= rem_d;
            prev_q  <= prev_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sel_cnt   = (int'(rd_sel) < N_SIG) ? cnt_q[rd_sel] : '0;
    assign total_cnt = total_q;
    assign busy      = (state_q == COUNT);
    assign done      = (state_q == DONE);
    assign overflow  = ovf_q;
endmodule
